axis_matvec_arbiter: RTL
========================

AXIS_MATVEC_ARBITER -- requirements
Module: axis_matvec_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 2, number of requester port pairs (>=2).
REQ-002 SHALL have parameters R, C, W_X, W_K, defaults 8, 8, 8, 8, matching the shared axis_matvec_mul engine.
REQ-003 SHALL have parameter DEPTH, default 4, in-flight ID FIFO depth (power of 2).
REQ-004 SHALL derive localparams W_Y = W_X+W_K+$clog2(C), BUS_IN_W = R*C*W_K+C*W_X, BUS_OUT_W = R*W_Y, W_ID = $clog2(N_REQ).
REQ-005 SHALL have one clock and a synchronous, active-high reset; ports clk and rst.
REQ-006 Ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  sync reset, active-high.
- s_axis_kx_tdata  in  N_REQ*BUS_IN_W  per-requester {k, x}; lane i = bits [i*BUS_IN_W +: BUS_IN_W].
- s_axis_kx_tvalid  in  N_REQ  per-requester valid.
- s_axis_kx_tready  out  N_REQ  per-requester ready.
- m_axis_y_tdata  out  N_REQ*BUS_OUT_W  per-requester result lanes.
- m_axis_y_tvalid  out  N_REQ  per-requester result valid.
- m_axis_y_tready  in  N_REQ  per-requester result ready.
- e_kx_tdata  out  BUS_IN_W  to engine input.
- e_kx_tvalid  out  1  engine input valid.
- e_kx_tready  in  1  engine input ready.
- e_y_tdata  in  BUS_OUT_W  engine result.
- e_y_tvalid  in  1  engine result valid.
- e_y_tready  out  1  engine result ready.
- busy  out  1  high while the ID FIFO is non-empty.
- err  out  1  sticky protocol-error flag.

Function
REQ-007 Grant SHALL be round-robin: the lowest i >= rr_ptr (modulo N_REQ) with s_axis_kx_tvalid[i]=1; rr_ptr is a register.
REQ-008 No grant SHALL be issued while the ID FIFO is full; all s_axis_kx_tready SHALL then be 0 (no push-through even with a same-cycle pop).
REQ-009 e_kx_tdata SHALL equal the granted lane; e_kx_tvalid = granted valid; s_axis_kx_tready[g] = e_kx_tready, all other readys 0.
REQ-010 If e_kx_tvalid=1 and e_kx_tready=0, the grant SHALL lock (registered lock bit plus lock_id) until the handshake, regardless of new valids.
REQ-011 On an input handshake: push the granted ID into the FIFO, set rr_ptr = (g+1) mod N_REQ, clear the lock; zero added latency (combinational path).
REQ-012 Results SHALL route strictly in order: head ID h; m_axis_y_tvalid[h] = e_y_tvalid; e_y_tready = m_axis_y_tready[h]; other m_axis_y_tvalid 0.
REQ-013 All m_axis_y_tdata lanes SHALL carry e_y_tdata (broadcast); only the tvalid bits qualify them.
REQ-014 On an output handshake, pop the FIFO; a simultaneous push and pop SHALL keep occupancy unchanged.
REQ-015 If e_y_tvalid=1 while the FIFO is empty: e_y_tready=0, all m_axis_y_tvalid=0, err set to 1 until reset.
REQ-016 Data SHALL pass unmodified; the arbiter does no arithmetic.

Reset
REQ-017 While rst=1 at a clk edge: rr_ptr=0, lock=0, FIFO empty, err=0.
REQ-018 Outputs after reset: busy=0, err=0, all m_axis_y_tvalid=0, e_y_tready=0; e_kx_tvalid follows the inputs per REQ-007..009.
REQ-019 Reset mid-operation SHALL discard all in-flight IDs; the engine is reset on the same rst.

Verification
REQ-020 N_REQ=2, both valid from cycle 1, engine always ready -> grants alternate 0,1,0,1; results appear on ports 0,1,0,1 in order.
REQ-021 Engine outputs held off (e_y_tvalid=0), port 0 streams -> exactly 4 accepts, then s_axis_kx_tready=00; one result popped -> exactly one further accept.
REQ-022 Port 0 valid, e_kx_tready=0 for 3 cycles, port 1 valid from 2nd cycle -> e_kx_tdata/e_kx_tvalid stable on lane 0 until handshake; next grant is port 1.
REQ-023 FIFO holds IDs {0,1}, m_axis_y_tready=00 -> e_y_tready=0, m_axis_y_tvalid=01 held; raise port 1 ready only -> no transfer; raise port 0 -> pop, then port 1 served.
REQ-024 rst pulsed with 2 outstanding -> busy=0, err=0, rr_ptr=0; inject e_y_tvalid=1 -> err=1 and stays 1.
REQ-025 Arbiter plus axis_matvec_mul, 500 random signed vectors per port, random valid/ready at 10% -> every port's results match the golden signed sum of k[r][c]*x[c], in order.

Source files
------------

// File: rtl/axis_matvec_arbiter.sv
// Round-robin arbiter that shares one axis_matvec_mul engine among N_REQ AXI-Stream
// requesters; an in-order ID FIFO routes each engine result back to the port that issued it.
//
// Handshake rule (all streams): a beat transfers on a rising clk edge where tvalid and tready
// are both 1. A source holds tvalid and tdata stable until that edge. Readys here depend
// combinationally on the valids.
module axis_matvec_arbiter #(
  parameter int N_REQ = 2,
  parameter int R     = 8,
  parameter int C     = 8,
  parameter int W_X   = 8,
  parameter int W_K   = 8,
  parameter int DEPTH = 4,
  localparam int W_Y       = W_X + W_K + $clog2(C),
  localparam int BUS_IN_W  = R * C * W_K + C * W_X,
  localparam int BUS_OUT_W = R * W_Y,
  localparam int W_ID      = $clog2(N_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_REQ*BUS_IN_W-1:0]      s_axis_kx_tdata,
  input  logic [N_REQ-1:0]               s_axis_kx_tvalid,
  output logic [N_REQ-1:0]               s_axis_kx_tready,
  output logic [N_REQ*BUS_OUT_W-1:0]     m_axis_y_tdata,
  output logic [N_REQ-1:0]               m_axis_y_tvalid,
  input  logic [N_REQ-1:0]               m_axis_y_tready,
  output logic [BUS_IN_W-1:0]            e_kx_tdata,
  output logic                           e_kx_tvalid,
  input  logic                           e_kx_tready,
  input  logic [BUS_OUT_W-1:0]           e_y_tdata,
  input  logic                           e_y_tvalid,
  output logic                           e_y_tready,
  output logic                           busy,
  output logic                           err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [W_ID-1:0] r_rr_ptr;
  logic            r_lock;
  logic [W_ID-1:0] r_lock_id;
  logic [W_ID-1:0] r_fifo [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic            r_err;

  logic            w_full;
  logic            w_empty;
  logic            w_found;
  logic [W_ID-1:0] w_idx;
  logic [W_ID-1:0] w_scan_id;
  logic [W_ID-1:0] w_grant_id;
  logic            w_grant_vld;
  logic            w_push;
  logic            w_pop;
  logic [W_ID-1:0] w_head;
  logic [BUS_IN_W-1:0] w_kx_data;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);

  // Round-robin scan starting at r_rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    w_found   = 1'b0;
    w_idx     = '0;
    w_scan_id = r_rr_ptr;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = W_ID'((int'(r_rr_ptr) + k) % N_REQ);
      if (!w_found && s_axis_kx_tvalid[w_idx]) begin
        w_found   = 1'b1;
        w_scan_id = w_idx;
      end
    end
  end

  // A stalled grant stays on the locked port; a full FIFO blocks every grant.
  assign w_grant_id  = r_lock ? r_lock_id : w_scan_id;
  assign w_grant_vld = !w_full && (r_lock ? s_axis_kx_tvalid[r_lock_id] : w_found);

  always_comb begin
    w_kx_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant_id == W_ID'(i)) w_kx_data = s_axis_kx_tdata[i*BUS_IN_W +: BUS_IN_W];
    end
  end

  assign e_kx_tdata  = w_kx_data;
  assign e_kx_tvalid = w_grant_vld;
  assign w_push      = w_grant_vld && e_kx_tready;

  always_comb begin
    s_axis_kx_tready = '0;
    if (w_grant_vld) s_axis_kx_tready[w_grant_id] = e_kx_tready;
  end

  // Results go only to the port at the FIFO head; with nothing outstanding they are refused.
  assign w_head = r_fifo[r_rd_ptr];

  always_comb begin
    m_axis_y_tvalid = '0;
    e_y_tready      = 1'b0;
    if (!w_empty) begin
      m_axis_y_tvalid[w_head] = e_y_tvalid;
      e_y_tready              = m_axis_y_tready[w_head];
    end
  end

  assign w_pop          = e_y_tvalid && e_y_tready;
  assign m_axis_y_tdata = {N_REQ{e_y_tdata}};
  assign busy           = !w_empty;
  assign err            = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr  <= '0;
      r_lock    <= 1'b0;
      r_lock_id <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        r_rr_ptr <= (w_grant_id == W_ID'(N_REQ - 1)) ? '0 : w_grant_id + W_ID'(1);
        r_lock   <= 1'b0;
      end else if (w_grant_vld) begin
        r_lock    <= 1'b1;
        r_lock_id <= w_grant_id;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
      if (e_y_tvalid && w_empty) r_err <= 1'b1;
    end
  end

  // ID storage needs no reset: entries are only read behind a valid count.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_grant_id;
  end

endmodule
